// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one overlapping Moore "1011" detector among N_CH
// serial streams, with per-channel detector state and saturating match counters.
module seq_det_rr_sched #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       bit_in,
  input  logic [N_CH-1:0]       ch_clr,
  output logic [N_CH-1:0]       gnt,
  output logic                  det_valid,
  output logic [CH_W-1:0]       det_ch,
  output logic                  det_out,
  output logic [N_CH*CNT_W-1:0] match_cnt,
  output logic [N_CH*3-1:0]     ch_state
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1'b1);

  function automatic state_t fsm_next(input state_t cur, input logic b);
    case (cur)
      S0:      fsm_next = b ? S1 : S0;
      S1:      fsm_next = b ? S1 : S2;
      S2:      fsm_next = b ? S3 : S0;
      S3:      fsm_next = b ? S4 : S2;
      S4:      fsm_next = b ? S1 : S2;
      default: fsm_next = S0;
    endcase
  endfunction

  state_t             st  [N_CH];
  state_t             nxt [N_CH];
  logic [CNT_W-1:0]   cnt [N_CH];
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    gnt_idx;
  logic [CH_W-1:0]    idx;
  logic [N_CH-1:0]    elig;
  logic               found;

  // Candidate next state of every channel for its presented bit.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      nxt[k] = fsm_next(st[k], bit_in[k]);
    end
  end

  // Arbiter: first eligible channel at or after rr_ptr; a cleared channel sits out.
  always_comb begin
    gnt     = {N_CH{1'b0}};
    found   = 1'b0;
    gnt_idx = {CH_W{1'b0}};
    idx     = {CH_W{1'b0}};
    if (rst) begin
      elig = {N_CH{1'b0}};
    end else begin
      elig = req & ~ch_clr;
    end
    for (int i = 0; i < N_CH; i++) begin
      idx = rr_ptr + CH_W'(i);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end else begin
        found   = found;
      end
    end
    gnt[gnt_idx] = found;
  end

  // Per-channel state/counters, pointer and the registered result of the shared detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        st[k]  <= S0;
        cnt[k] <= {CNT_W{1'b0}};
      end
      rr_ptr    <= {CH_W{1'b0}};
      det_valid <= 1'b0;
      det_ch    <= {CH_W{1'b0}};
      det_out   <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (ch_clr[k]) begin
          st[k]  <= S0;
          cnt[k] <= {CNT_W{1'b0}};
        end else if (gnt[k]) begin
          st[k] <= nxt[k];
          if (nxt[k] == S4 && cnt[k] != CNT_MAX) begin
            cnt[k] <= cnt[k] + CNT_ONE;
          end
        end
      end
      det_valid <= found;
      if (found) begin
        rr_ptr  <= gnt_idx + CH_ONE;
        det_ch  <= gnt_idx;
        det_out <= (nxt[gnt_idx] == S4);
      end
    end
  end

  // Flatten per-channel registers onto the packed debug/status buses.
  always_comb begin
    match_cnt = {(N_CH*CNT_W){1'b0}};
    ch_state  = {(N_CH*3){1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      match_cnt[k*CNT_W +: CNT_W] = cnt[k];
      ch_state[k*3 +: 3]          = st[k];
    end
  end

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Table-driven bench for seq_det_rr_sched with a scoreboard of expected detector results.
module tb_seq_det_rr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req, bit_in, ch_clr, gnt;
  logic        det_valid, det_out;
  logic [1:0]  det_ch;
  logic [31:0] match_cnt;
  logic [11:0] ch_state;

  logic [3:0]  req2, bit_in2, ch_clr2, gnt2;
  logic        det_valid2, det_out2;
  logic [1:0]  det_ch2;
  logic [7:0]  match_cnt2;
  logic [11:0] ch_state2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] bits;
    logic [3:0] clr;
    logic [3:0] egnt;
    logic [1:0] ech;
    logic       eout;
    logic [7:0] ecnt;
    logic [2:0] est;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic       out;
    logic [7:0] cnt;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  seq_det_rr_sched #(.N_CH(4), .CH_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .ch_clr(ch_clr),
    .gnt(gnt), .det_valid(det_valid), .det_ch(det_ch), .det_out(det_out),
    .match_cnt(match_cnt), .ch_state(ch_state)
  );

  seq_det_rr_sched #(.N_CH(4), .CH_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req2), .bit_in(bit_in2), .ch_clr(ch_clr2),
    .gnt(gnt2), .det_valid(det_valid2), .det_ch(det_ch2), .det_out(det_out2),
    .match_cnt(match_cnt2), .ch_state(ch_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] g, input logic [1:0] ch, input logic o,
                              input logic [7:0] cn, input logic [2:0] s);
    vec_t v;
    v.req = r; v.bits = b; v.clr = c; v.egnt = g;
    v.ech = ch; v.eout = o; v.ecnt = cn; v.est = s;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; bit_in = 4'b0; ch_clr = 4'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    int   c;
    req = v.req; bit_in = v.bits; ch_clr = v.clr;
    #1;
    chk({tag, "_gnt"}, 32'(gnt), 32'(v.egnt));
    if (|v.egnt) begin
      e.ch = v.ech; e.out = v.eout; e.cnt = v.ecnt; e.st = v.est;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    chk({tag, "_det_valid"}, 32'(det_valid), 32'(|v.egnt));
    if (det_valid) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        c = int'(e.ch);
        chk({tag, "_det_ch"}, 32'(det_ch), 32'(e.ch));
        chk({tag, "_det_out"}, 32'(det_out), 32'(e.out));
        chk({tag, "_match_cnt"}, 32'(match_cnt[c*8 +: 8]), 32'(e.cnt));
        chk({tag, "_ch_state"}, 32'(ch_state[c*3 +: 3]), 32'(e.st));
      end
    end
  endtask

  vec_t t1[7];
  vec_t t2[8];
  vec_t t3[8];
  vec_t t4[7];
  vec_t t6[3];

  initial begin
    logic [12:0] sat_stream;
    logic [1:0]  sat_exp;
    logic        hit;

    // Single channel 1011011 on channel 0.
    t1[0] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd1);
    t1[1] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd2);
    t1[2] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd3);
    t1[3] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'd1, 3'd4);
    t1[4] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd1, 3'd2);
    t1[5] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd1, 3'd3);
    t1[6] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'd2, 3'd4);
    // Fairness with all four requesting.
    for (int i = 0; i < 8; i++) begin
      t2[i] = mk(4'b1111, 4'b1111, 4'b0000, 4'(4'b0001 << (i % 4)), 2'(i % 4), 1'b0, 8'd0, 3'd1);
    end
    // Channels 0 and 2 interleaving 1011.
    t3[0] = mk(4'b0101, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd1);
    t3[1] = mk(4'b0101, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0, 8'd0, 3'd1);
    t3[2] = mk(4'b0101, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd2);
    t3[3] = mk(4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, 8'd0, 3'd2);
    t3[4] = mk(4'b0101, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd3);
    t3[5] = mk(4'b0101, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0, 8'd0, 3'd3);
    t3[6] = mk(4'b0101, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'd1, 3'd4);
    t3[7] = mk(4'b0101, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'd1, 3'd4);
    // Channel 1 to S3 with one prior hit, then clear collides with a 1 on it.
    t4[0] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 8'd0, 3'd1);
    t4[1] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0, 8'd0, 3'd2);
    t4[2] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 8'd0, 3'd3);
    t4[3] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 8'd1, 3'd4);
    t4[4] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0, 8'd1, 3'd2);
    t4[5] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 8'd1, 3'd3);
    t4[6] = mk(4'b0011, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b0, 8'd0, 3'd1);
    // Channel 3 to S3 before a mid-stream reset.
    t6[0] = mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 8'd0, 3'd1);
    t6[1] = mk(4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b0, 8'd0, 3'd2);
    t6[2] = mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 8'd0, 3'd3);

    req2 = 4'b0; bit_in2 = 4'b0; ch_clr2 = 4'b0;

    // Reset state, with requests present that must not be granted.
    rst = 1'b1; req = 4'b1111; bit_in = 4'b1111; ch_clr = 4'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    @(posedge clk); #1;
    chk("rst_det_valid", 32'(det_valid), 32'(0));
    chk("rst_det_ch", 32'(det_ch), 32'(0));
    chk("rst_det_out", 32'(det_out), 32'(0));
    chk("rst_match_cnt", match_cnt, 32'(0));
    chk("rst_ch_state", 32'(ch_state), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply(t1[i], "single");
    chk("single_final_cnt0", 32'(match_cnt[7:0]), 32'(2));
    chk("single_final_st0", 32'(ch_state[2:0]), 32'(4));

    do_reset();
    for (int i = 0; i < 8; i++) apply(t2[i], "fair");

    do_reset();
    for (int i = 0; i < 8; i++) apply(t3[i], "interleave");

    do_reset();
    for (int i = 0; i < 7; i++) apply(t4[i], "clear");
    chk("clear_st1", 32'(ch_state[5:3]), 32'(0));
    chk("clear_cnt1", 32'(match_cnt[15:8]), 32'(0));

    do_reset();
    for (int i = 0; i < 3; i++) apply(t6[i], "midrst");
    rst = 1'b1; req = 4'b1000; bit_in = 4'b1000; ch_clr = 4'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'(0));
    @(posedge clk); #1;
    chk("midrst_det_valid", 32'(det_valid), 32'(0));
    chk("midrst_st3", 32'(ch_state[11:9]), 32'(0));
    chk("midrst_det_out", 32'(det_out), 32'(0));
    rst = 1'b0;
    apply(mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 8'd0, 3'd1), "midrst_after");

    // Saturation on the 2-bit counter instance: hits after bits 4, 7, 10, 13.
    req = 4'b0; bit_in = 4'b0;
    sat_stream = 13'b1011011011011;
    sat_exp = 2'd0;
    for (int i = 0; i < 13; i++) begin
      req2 = 4'b0001; bit_in2 = {3'b000, sat_stream[12-i]};
      #1;
      chk("sat_gnt", 32'(gnt2), 32'(4'b0001));
      @(posedge clk); #1;
      hit = ((i % 3) == 0) && (i != 0);
      if (hit && sat_exp != 2'd3) sat_exp = sat_exp + 2'd1;
      chk("sat_det_valid", 32'(det_valid2), 32'(1));
      chk("sat_det_out", 32'(det_out2), 32'(hit));
      if (hit) chk("sat_cnt", 32'(match_cnt2[1:0]), 32'(sat_exp));
    end
    req2 = 4'b0;

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_rr_sched.md
# seq_det_rr_sched

Round-robin scheduler that time-shares one Moore "1011" detector (`seq_det_moore` behaviour, overlapping) among `N_CH` serial bit streams. It keeps a private detector state and match counter for each channel, grants one requesting channel per cycle, and advances only that channel's state. It sits between the serial front-end requesters and the status/interrupt logic, and replaces N separate detector instances.

## Interface
- `N_CH`, default 4: number of requesting channels (power of two, 2..16).
- `CH_W`, default 2: log2(`N_CH`); width of the channel index.
- `CNT_W`, default 8: width of each per-channel match counter.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_CH  per-channel request: channel has a valid bit on `bit_in`.
- `bit_in`  in  N_CH  per-channel serial data bit, sampled with `req`.
- `ch_clr`  in  N_CH  per-channel clear of that channel's state and counter.
- `gnt`  out  N_CH  one-hot grant, combinational; `bit_in[k]` is consumed on any edge where `gnt[k]` is high.
- `det_valid`  out  1  registered; a channel was advanced on the previous edge.
- `det_ch`  out  CH_W  registered; index of the channel that was advanced.
- `det_out`  out  1  registered; Moore output of that channel's new state (1 iff S4).
- `match_cnt`  out  N_CH*CNT_W  channel k occupies bits [k*CNT_W +: CNT_W]; saturating match count.
- `ch_state`  out  N_CH*3  channel k occupies bits [k*3 +: 3]; state encoding S0..S4 = 0..4 (debug).

## Operation
- Eligible set: `req & ~ch_clr`. If the set is empty, `gnt` is 0.
- Round-robin pointer `rr_ptr` (CH_W bits) marks the highest-priority channel. The grant goes to the first eligible channel scanning `rr_ptr`, `rr_ptr+1`, … modulo `N_CH`.
- On an edge with grant to k:
  - `rr_ptr` ← (k+1) mod `N_CH`.
  - State[k] ← next(State[k], `bit_in[k]`).
  - If the new state is S4, `match_cnt[k]` increments, holding at 2^CNT_W−1 once there.
- With no grant, `rr_ptr` and all states and counters hold.
- Moore FSM, per channel. Pattern is 1011 with overlap allowed.
  - S0: 1→S1, 0→S0.
  - S1: 0→S2, 1→S1.
  - S2: 1→S3, 0→S0.
  - S3: 1→S4, 0→S2.
  - S4: 1→S1, 0→S2. S4 output = 1.
  - Illegal codes 5..7 → S0.
- `ch_clr[k]` high at an edge:
  - State[k] ← S0 and `match_cnt[k]` ← 0.
  - Channel k is masked from arbitration that cycle, so no bit of channel k is lost or consumed ambiguously.
  - Other channels are unaffected.
- Only the granted channel's state changes on a given edge; non-granted channels keep their state indefinitely.

## Timing
- `gnt` is a pure combinational function of `req`, `ch_clr` and `rr_ptr`. The requester holds `req`/`bit_in` until it sees `gnt` high at a clock edge.
- Latency: a bit consumed at edge n produces the following, all stable during cycle n+1:
  - `det_valid`=1;
  - `det_ch`=k;
  - `det_out` = (new state == S4);
  - the updated `match_cnt[k]` and `ch_state[k]`.
- If nothing is granted at edge n, `det_valid`=0 in cycle n+1. `det_ch`/`det_out` hold their last values.
- Throughput: one bit per cycle in aggregate. Each of M continuously requesting channels is granted exactly once every M cycles (no starvation).
- Reset, effective at any edge including mid-stream:
  - all states S0, all `match_cnt` 0, `rr_ptr` 0;
  - `det_valid`, `det_ch`, `det_out` all 0.
  - Any request present in the reset cycle is not consumed (`gnt` forced 0 while `rst`=1).
- `ch_clr` and `rst` take priority over a concurrent state advance.

## Test plan
- Reset then single channel: `req`=0001, `bit_in[0]` = 1,0,1,1,0,1,1 on consecutive edges.
  - `det_out` = 0,0,0,1,0,0,1 (overlapping hit).
  - `match_cnt[0]`=2.
  - `ch_state[0]` ends at 4.
- Fairness: `req`=1111 held for 8 cycles from reset. `det_ch` sequence is 0,1,2,3,0,1,2,3 and each `gnt` is one-hot.
- Interleaving: channels 0 and 2 each feed 1011 while alternating grants with `req`=0101. Each channel reports `det_out`=1 on its own 4th consumed bit. A channel's states are not disturbed by the other.
- Clear collision: channel 1 in S3 with `req[1]`=1, `bit_in[1]`=1 and `ch_clr[1]`=1 on the same edge.
  - `gnt[1]`=0.
  - `ch_state[1]`=0 and `match_cnt[1]`=0 afterwards.
  - Another requester, if present, is granted instead.
- Saturation: with `CNT_W`=2, feed channel 0 the stream 1011011011011 (4 hits). `match_cnt[0]` reads 1,2,3,3.
- Mid-stream reset: assert `rst` one cycle while channel 3 is in S3 and `req`=1000.
  - Next cycle: `det_valid`=0 and `ch_state[3]`=0.
  - The following 1 leads to S1, not S4.
